// File: rtl/prt_pkg.sv
// prt_pkg
// Shared definitions for the packet reference table (PRT) and its clients
// (ingress writer, egress reader).
//   DATA_WIDTH     frame byte width; a PRT read word is DATA_WIDTH+1 bits
//   NUM_SLOTS      number of PRT slots
//   MEM_DEPTH      maximum bytes per frame
//   slot_t         slot index type
//   prt_word_t     one PRT word: {last, data}
//   egress_state_e egress reader control states
package prt_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_SLOTS  = 2;
  localparam int MEM_DEPTH  = 1518;
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } prt_word_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    READ,
    DRAIN,
    INVAL
  } egress_state_e;

endpackage

// File: rtl/prt_egress_skid.sv
// prt_egress_skid
// Two-entry skid buffer between the PRT read port and the transmit MAC.
// The MAC-facing outputs come straight from flops; the second entry absorbs
// the word popped in the cycle the MAC stalls, so the PRT side never needs
// to look at tx_ready combinationally.
//   CLK, RST            clock, asynchronous active-high reset
//   push_i              write one {last, data} word (only when !full_o)
//   push_data_i/last_i  word being written
//   full_o              both entries occupied
//   empty_o             no entry occupied
//   going_empty_o       the only remaining entry is accepted this cycle
//   tx_data_o/last_o    head entry, registered
//   tx_valid_o          head entry valid
//   tx_ready_i          MAC accepts head entry when valid & ready
module prt_egress_skid #(
  parameter int DATA_WIDTH = prt_pkg::DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  going_empty_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  output logic                  tx_last_o,
  input  logic                  tx_ready_i
);

  logic [DATA_WIDTH-1:0] head_data_q;
  logic                  head_last_q;
  logic                  head_valid_q;
  logic [DATA_WIDTH-1:0] spare_data_q;
  logic                  spare_last_q;
  logic                  spare_valid_q;
  logic                  pop;

  assign pop = head_valid_q & tx_ready_i;

  // The spare entry is only ever occupied behind a valid head.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_data_q   <= '0;
      head_last_q   <= 1'b0;
      head_valid_q  <= 1'b0;
      spare_data_q  <= '0;
      spare_last_q  <= 1'b0;
      spare_valid_q <= 1'b0;
    end else if (pop) begin
      if (spare_valid_q) begin
        head_data_q <= spare_data_q;
        head_last_q <= spare_last_q;
        if (push_i) begin
          spare_data_q <= push_data_i;
          spare_last_q <= push_last_i;
        end else begin
          spare_valid_q <= 1'b0;
        end
      end else if (push_i) begin
        head_data_q <= push_data_i;
        head_last_q <= push_last_i;
      end else begin
        head_valid_q <= 1'b0;
      end
    end else if (push_i) begin
      if (head_valid_q) begin
        spare_data_q  <= push_data_i;
        spare_last_q  <= push_last_i;
        spare_valid_q <= 1'b1;
      end else begin
        head_data_q  <= push_data_i;
        head_last_q  <= push_last_i;
        head_valid_q <= 1'b1;
      end
    end
  end

  assign full_o        = head_valid_q & spare_valid_q;
  assign empty_o       = ~head_valid_q;
  assign going_empty_o = pop & ~spare_valid_q & ~push_i;
  assign tx_data_o     = head_data_q;
  assign tx_last_o     = head_last_q;
  assign tx_valid_o    = head_valid_q;

endmodule

// File: rtl/prt_egress_reader.sv
// prt_egress_reader
// Drain stage of the PRT: takes a slot + forward/drop verdict, reads the
// forwarded frame out of the PRT byte by byte into the transmit MAC, then
// invalidates the slot. One frame in flight at a time.
//   CLK, RST                          clock, asynchronous active-high reset
//   verdict_valid/ready/slot/drop     verdict handshake from the filter
//   EN/RDY_start_reading_prt_entry    PRT read start method (+ slot)
//   EN/RDY_read_prt_entry             PRT word pop method, read_prt_entry data
//   EN/RDY_invalidate_prt_entry       PRT slot free method (+ slot)
//   tx_data/valid/last/ready          byte stream to the MAC
//   frames_sent/frames_dropped        wrapping 16-bit frame counters
//   err_overlength                    sticky: a frame hit MEM_DEPTH with no last
module prt_egress_reader #(
  parameter int  DATA_WIDTH = prt_pkg::DATA_WIDTH,
  parameter int  NUM_SLOTS  = prt_pkg::NUM_SLOTS,
  parameter int  MEM_DEPTH  = prt_pkg::MEM_DEPTH,
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  verdict_valid,
  input  logic [SLOT_W-1:0]     verdict_slot,
  input  logic                  verdict_drop,
  output logic                  verdict_ready,
  output logic                  EN_start_reading_prt_entry,
  output logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
  input  logic                  RDY_start_reading_prt_entry,
  output logic                  EN_read_prt_entry,
  input  logic [DATA_WIDTH:0]   read_prt_entry,
  input  logic                  RDY_read_prt_entry,
  output logic                  EN_invalidate_prt_entry,
  output logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
  input  logic                  RDY_invalidate_prt_entry,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [15:0]           frames_sent,
  output logic [15:0]           frames_dropped,
  output logic                  err_overlength
);

  import prt_pkg::*;

  localparam int CNT_W = $clog2(MEM_DEPTH + 1);

  egress_state_e     state_q, state_d;
  logic [SLOT_W-1:0] slot_q;
  logic              drop_q;
  logic              alive_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q;
  logic [15:0]       sent_q, dropped_q;

  logic              accept;
  logic              read_fire;
  logic              inval_fire;
  logic              at_limit;
  logic              word_last;
  logic              skid_push, skid_push_last;
  logic              skid_full, skid_empty, skid_going_empty;

  assign word_last = read_prt_entry[DATA_WIDTH];
  // This pop is the MEM_DEPTH-th byte of the frame.
  assign at_limit  = (cnt_q == CNT_W'(MEM_DEPTH - 1));

  always_comb begin
    state_d                    = state_q;
    cnt_d                      = cnt_q;
    verdict_ready              = 1'b0;
    accept                     = 1'b0;
    EN_start_reading_prt_entry = 1'b0;
    EN_read_prt_entry          = 1'b0;
    EN_invalidate_prt_entry    = 1'b0;
    read_fire                  = 1'b0;
    inval_fire                 = 1'b0;
    skid_push                  = 1'b0;
    skid_push_last             = 1'b0;
    case (state_q)
      IDLE: begin
        // alive_q keeps verdict_ready low until the first edge after reset.
        verdict_ready = alive_q;
        accept        = alive_q & verdict_valid;
        if (accept) begin
          state_d = verdict_drop ? INVAL : START;
        end
      end
      START: begin
        cnt_d                      = '0;
        EN_start_reading_prt_entry = RDY_start_reading_prt_entry;
        if (RDY_start_reading_prt_entry) begin
          state_d = READ;
        end
      end
      READ: begin
        read_fire         = RDY_read_prt_entry & ~skid_full;
        EN_read_prt_entry = read_fire;
        if (read_fire) begin
          skid_push      = 1'b1;
          skid_push_last = word_last | at_limit;
          cnt_d          = cnt_q + CNT_W'(1);
          if (word_last | at_limit) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave on the edge the final byte is accepted, not one cycle later.
        if (skid_empty | skid_going_empty) begin
          state_d = INVAL;
        end
      end
      INVAL: begin
        EN_invalidate_prt_entry = RDY_invalidate_prt_entry;
        inval_fire              = RDY_invalidate_prt_entry;
        if (RDY_invalidate_prt_entry) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      drop_q    <= 1'b0;
      alive_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alive_q <= 1'b1;
      if (accept) begin
        slot_q <= verdict_slot;
        drop_q <= verdict_drop;
      end
      if (read_fire & at_limit & ~word_last) begin
        err_q <= 1'b1;
      end
      if (inval_fire) begin
        if (drop_q) begin
          dropped_q <= dropped_q + 16'd1;
        end else begin
          sent_q <= sent_q + 16'd1;
        end
      end
    end
  end

  prt_egress_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .CLK          (CLK),
    .RST          (RST),
    .push_i       (skid_push),
    .push_data_i  (read_prt_entry[DATA_WIDTH-1:0]),
    .push_last_i  (skid_push_last),
    .full_o       (skid_full),
    .empty_o      (skid_empty),
    .going_empty_o(skid_going_empty),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_last_o    (tx_last),
    .tx_ready_i   (tx_ready)
  );

  assign start_reading_prt_entry_slot = slot_q;
  assign invalidate_prt_entry_slot    = slot_q;
  assign frames_sent                  = sent_q;
  assign frames_dropped               = dropped_q;
  assign err_overlength               = err_q;

endmodule
